fmc_sram_arbiter: RTL

- Shares one single-port frame SRAM between a pixel write stream and a display read stream.
- Each port has a per-frame address counter that runs in raster order.
- Conflicts are resolved by round-robin; at most one SRAM access is issued per cycle.
- Sits between the input pixel interface, the display fetch logic and the frame SRAM (active-low CSN/WEN, registered read data one cycle after the access edge).

---
 rtl/fmc_pkg.sv | 18 +
 rtl/fmc_frame_addr_cnt.sv | 41 ++++
 rtl/fmc_sram_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fmc_pkg.sv
// fmc_pkg: shared types and defaults for the frame SRAM arbiter.
// Grant encoding, default geometry and frame size helper.
package fmc_pkg;

  typedef enum logic {
    GRANT_WRITE = 1'b0,
    GRANT_READ  = 1'b1
  } grant_t;

  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_H_ACT      = 1080;
  localparam int DEF_V_ACT      = 2400;

  function automatic int frame_size(input int h, input int v);
    return h * v;
  endfunction

endpackage

// File: rtl/fmc_frame_addr_cnt.sv
// fmc_frame_addr_cnt: raster-order frame address counter.
// SOF forces address 0; wrap pulses after the last pixel.
module fmc_frame_addr_cnt
  import fmc_pkg::*;
#(
  parameter int H_ACT      = DEF_H_ACT,
  parameter int V_ACT      = DEF_V_ACT,
  parameter int ADDR_WIDTH = $clog2(frame_size(H_ACT, V_ACT))
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  advance,
  input  logic                  sof,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  wrap
);

  localparam int FRAME_SIZE = frame_size(H_ACT, V_ACT);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(FRAME_SIZE - 1);

  logic [ADDR_WIDTH-1:0] cnt;
  logic                  at_last;

  assign addr    = sof ? '0 : cnt;
  assign at_last = (addr == LAST);

  // Advance on handshake; wrap to 0 and flag frame end.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= advance & at_last;
      if (advance) begin
        cnt <= at_last ? '0 : addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fmc_sram_arbiter.sv
// fmc_sram_arbiter: round-robin sharing of one frame SRAM
// between a pixel write stream and a display read stream.
module fmc_sram_arbiter
  import fmc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int H_ACT      = DEF_H_ACT,
  parameter int V_ACT      = DEF_V_ACT,
  parameter int ADDR_WIDTH = $clog2(frame_size(H_ACT, V_ACT))
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WR_SOF,
  input  logic                  WR_VALID,
  output logic                  WR_READY,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  WR_FRAME_DONE,
  input  logic                  RD_SOF,
  input  logic                  RD_REQ,
  output logic                  RD_READY,
  output logic                  RD_DVALID,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_FRAME_DONE,
  output logic                  SRAM_CSN,
  output logic                  SRAM_WEN,
  output logic [ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic [DATA_WIDTH-1:0] SRAM_DIN,
  input  logic [DATA_WIDTH-1:0] SRAM_DOUT
);

  grant_t                last_grant;
  logic                  gnt_w;
  logic                  gnt_r;
  logic                  rd_pend;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // Round-robin: on conflict the side not granted last wins.
  always_comb begin
    gnt_w = 1'b0;
    gnt_r = 1'b0;
    if (WR_VALID && RD_REQ) begin
      gnt_w = (last_grant == GRANT_READ);
      gnt_r = (last_grant == GRANT_WRITE);
    end else begin
      gnt_w = WR_VALID;
      gnt_r = RD_REQ;
    end
  end

  assign WR_READY = gnt_w;
  assign RD_READY = gnt_r;
  assign RD_DATA  = SRAM_DOUT;

  fmc_frame_addr_cnt #(
    .H_ACT     (H_ACT),
    .V_ACT     (V_ACT),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_wr_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .advance(gnt_w),
    .sof    (WR_SOF),
    .addr   (wr_addr),
    .wrap   (WR_FRAME_DONE)
  );

  fmc_frame_addr_cnt #(
    .H_ACT     (H_ACT),
    .V_ACT     (V_ACT),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_rd_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .advance(gnt_r),
    .sof    (RD_SOF),
    .addr   (rd_addr),
    .wrap   (RD_FRAME_DONE)
  );

  // Remember the last granted side; idle cycles keep it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_grant <= GRANT_READ;
    end else if (gnt_w) begin
      last_grant <= GRANT_WRITE;
    end else if (gnt_r) begin
      last_grant <= GRANT_READ;
    end
  end

  // SRAM command register; address/data hold when idle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SRAM_CSN  <= 1'b1;
      SRAM_WEN  <= 1'b1;
      SRAM_ADDR <= '0;
      SRAM_DIN  <= '0;
    end else begin
      SRAM_CSN <= ~(gnt_w | gnt_r);
      SRAM_WEN <= ~gnt_w;
      if (gnt_w) begin
        SRAM_ADDR <= wr_addr;
        SRAM_DIN  <= WR_DATA;
      end else if (gnt_r) begin
        SRAM_ADDR <= rd_addr;
      end
    end
  end

  // Read return pipeline matching the SRAM output register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_pend   <= 1'b0;
      RD_DVALID <= 1'b0;
    end else begin
      rd_pend   <= gnt_r;
      RD_DVALID <= rd_pend;
    end
  end

endmodule
